// File: rtl/sys_decoder_pkg.sv
// sys_decoder_pkg -- shared definitions for the M68K system address decoder.
//
// Contents:
//   - region-table field widths (shift amount, region index)
//   - bus-cycle state enum used by sys_decoder
//   - per-PCB region-table constants (packed, region 0 in the LSBs)
//   - addr_match(): the "same block after shifting" comparison used by the matcher
//
// Optional feature: SYS_DECODER_BERR_EN (see sys_decoder.sv) does not change
// anything in this package.
package sys_decoder_pkg;

  // Field widths of one region-table entry.
  localparam int SHIFT_W = 5;
  localparam int IDX_W   = 5;

  // Bus-cycle sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_READY = 3'd2,
    ST_ACK   = 3'd3,
    ST_BERR  = 3'd4
  } state_t;

  // Demo PCB memory map (8 regions, 24-bit bus, 4-bit wait counts).
  //   r0 000000/18 w0        r4 C00000/16 w2
  //   r1 480000/14 w3        r5 400000/16 w1 (shadowed by r2 inside 404000/11)
  //   r2 404000/11 w0        r6 200000/20 w1 + ext_ready
  //   r3 840000/16 w0 + ext_ready (SDRAM)   r7 E00000/20 w15
  localparam int PCB_DEMO_REGIONS = 8;
  localparam int PCB_DEMO_ADDR_W  = 24;
  localparam int PCB_DEMO_WAIT_W  = 4;

  localparam logic [PCB_DEMO_REGIONS*PCB_DEMO_ADDR_W-1:0] PCB_DEMO_BASE = {
    24'hE00000, 24'h200000, 24'h400000, 24'hC00000,
    24'h840000, 24'h404000, 24'h480000, 24'h000000
  };
  localparam logic [PCB_DEMO_REGIONS*SHIFT_W-1:0] PCB_DEMO_SHIFT = {
    5'd20, 5'd20, 5'd16, 5'd16, 5'd16, 5'd11, 5'd14, 5'd18
  };
  localparam logic [PCB_DEMO_REGIONS*PCB_DEMO_WAIT_W-1:0] PCB_DEMO_WAIT = {
    4'd15, 4'd1, 4'd1, 4'd2, 4'd0, 4'd0, 4'd3, 4'd0
  };
  localparam logic [PCB_DEMO_REGIONS-1:0] PCB_DEMO_READY = 8'b0100_1000;

  // True when addr and base fall in the same 2**shift-byte block.
  function automatic logic addr_match(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [SHIFT_W-1:0] shift);
    return (addr >> shift) == (base >> shift);
  endfunction

endpackage

// File: rtl/sys_decoder_region_match.sv
// region_match -- combinational region-table lookup for sys_decoder.
//
// Ports:
//   addr         in   ADDR_W   CPU address
//   hit          out  1        some region matched
//   idx          out  5        index of the matching region (0 when no hit)
//   wait_states  out  WAIT_W   wait-state count of that region (0 when no hit)
//   ready        out  1        region needs ext_ready (0 when no hit)
//
// The table is supplied as packed parameters, region i occupying slice i.
module region_match
  import sys_decoder_pkg::*;
#(
  parameter int NUM_REGIONS = 24,
  parameter int ADDR_W      = 24,
  parameter int WAIT_W      = 4,
  parameter logic [NUM_REGIONS*ADDR_W-1:0]  REGION_BASE  = '0,
  parameter logic [NUM_REGIONS*SHIFT_W-1:0] REGION_SHIFT = '0,
  parameter logic [NUM_REGIONS*WAIT_W-1:0]  REGION_WAIT  = '0,
  parameter logic [NUM_REGIONS-1:0]         REGION_READY = '0
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [IDX_W-1:0]  idx,
  output logic [WAIT_W-1:0] wait_states,
  output logic              ready
);

  // Priority search: scan from the top index down so the lowest matching
  // index is the last one written and therefore wins on overlap.
  always_comb begin
    hit         = 1'b0;
    idx         = '0;
    wait_states = '0;
    ready       = 1'b0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (addr_match(32'(addr), 32'(REGION_BASE[i*ADDR_W +: ADDR_W]),
                     REGION_SHIFT[i*SHIFT_W +: SHIFT_W])) begin
        hit         = 1'b1;
        idx         = IDX_W'(i);
        wait_states = REGION_WAIT[i*WAIT_W +: WAIT_W];
        ready       = REGION_READY[i];
      end else begin
        // keep whatever a higher index produced
        hit = hit;
      end
    end
  end

endmodule

// File: rtl/sys_decoder.sv
// sys_decoder -- M68K address decoder and bus-cycle sequencer.
//
// Decodes cpu_a against a parameterised region table when the address strobe
// is seen, latches a one-hot chip select for the whole bus cycle, counts the
// region's wait states, optionally waits for ext_ready, then asserts DTACK
// until the CPU drops the strobe.
//
// Ports:
//   clk_sys      in   1            system clock (single clock domain)
//   reset_n      in   1            synchronous active-low reset
//   cpu_a        in   ADDR_W       CPU address
//   cpu_as_n     in   1            address strobe, active-low
//   ext_ready    in   1            ready from slow targets (SDRAM etc.)
//   cs           out  NUM_REGIONS  registered one-hot region selects
//   cpu_dtack_n  out  1            data acknowledge, active-low
//   cpu_berr_n   out  1            bus error, active-low
//   hit_idx      out  5            latched region index, valid while cs != 0
//
// Build option SYS_DECODER_BERR_EN: when defined, unmatched addresses and
// cycles that spend TIMEOUT clocks in WAIT/READY end with a bus error.
// When undefined, unmatched addresses get a zero-wait DTACK, READY waits
// forever and cpu_berr_n is tied high.
module sys_decoder
  import sys_decoder_pkg::*;
#(
  parameter int NUM_REGIONS = 24,
  parameter int ADDR_W      = 24,
  parameter int WAIT_W      = 4,
  parameter int TIMEOUT     = 255,
  parameter logic [NUM_REGIONS*ADDR_W-1:0]  REGION_BASE  = '0,
  parameter logic [NUM_REGIONS*SHIFT_W-1:0] REGION_SHIFT = '0,
  parameter logic [NUM_REGIONS*WAIT_W-1:0]  REGION_WAIT  = '0,
  parameter logic [NUM_REGIONS-1:0]         REGION_READY = '0
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic [ADDR_W-1:0]      cpu_a,
  input  logic                   cpu_as_n,
  input  logic                   ext_ready,
  output logic [NUM_REGIONS-1:0] cs,
  output logic                   cpu_dtack_n,
  output logic                   cpu_berr_n,
  output logic [IDX_W-1:0]       hit_idx
);

  // hit_idx is 5 bits and the matcher compares in 32 bits.
  if (NUM_REGIONS < 1 || NUM_REGIONS > 32 || ADDR_W > 32 || TIMEOUT < 1) begin : g_bad_params
    $error("sys_decoder: unsupported NUM_REGIONS/ADDR_W/TIMEOUT");
  end

  localparam logic [NUM_REGIONS-1:0] CS_ONE = NUM_REGIONS'(1'b1);

  logic              m_hit;
  logic [IDX_W-1:0]  m_idx;
  logic [WAIT_W-1:0] m_wait;
  logic              m_ready;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              need_ready;

  region_match #(
    .NUM_REGIONS  (NUM_REGIONS),
    .ADDR_W       (ADDR_W),
    .WAIT_W       (WAIT_W),
    .REGION_BASE  (REGION_BASE),
    .REGION_SHIFT (REGION_SHIFT),
    .REGION_WAIT  (REGION_WAIT),
    .REGION_READY (REGION_READY)
  ) u_match (
    .addr        (cpu_a),
    .hit         (m_hit),
    .idx         (m_idx),
    .wait_states (m_wait),
    .ready       (m_ready)
  );

`ifdef SYS_DECODER_BERR_EN
  // Wide enough to hold TIMEOUT itself.
  localparam int TMO_W = $clog2(TIMEOUT + 2);

  logic             miss;
  logic [TMO_W-1:0] tmo_cnt;
  logic [TMO_W-1:0] tmo_next;
  logic             tmo_hit;

  // Cycles spent since the strobe was accepted, including this edge.
  always_comb begin
    tmo_next = tmo_cnt + TMO_W'(1);
    tmo_hit  = (tmo_next >= TMO_W'(TIMEOUT));
  end
`else
  assign cpu_berr_n = 1'b1;
`endif

  // Bus-cycle sequencer; every output is a register written only here.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cs          <= '0;
      hit_idx     <= '0;
      wait_cnt    <= '0;
      need_ready  <= 1'b0;
      cpu_dtack_n <= 1'b1;
`ifdef SYS_DECODER_BERR_EN
      miss        <= 1'b0;
      tmo_cnt     <= '0;
      cpu_berr_n  <= 1'b1;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (!cpu_as_n) begin
            // Matcher outputs are all-zero on a miss, so no extra muxing
            // is needed for hit_idx / wait_cnt / need_ready.
            cs         <= m_hit ? (CS_ONE << m_idx) : '0;
            hit_idx    <= m_idx;
            wait_cnt   <= m_wait;
            need_ready <= m_ready;
`ifdef SYS_DECODER_BERR_EN
            miss       <= ~m_hit;
            tmo_cnt    <= '0;
`endif
            state      <= ST_WAIT;
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_WAIT: begin
`ifdef SYS_DECODER_BERR_EN
          tmo_cnt <= tmo_next;
`endif
          if (cpu_as_n) begin
            // aborted cycle: drop the select, no acknowledge
            cs    <= '0;
            state <= ST_IDLE;
          end
`ifdef SYS_DECODER_BERR_EN
          else if (tmo_hit) begin
            cs         <= '0;
            cpu_berr_n <= 1'b0;
            state      <= ST_BERR;
          end
`endif
          else if (wait_cnt != WAIT_W'(0)) begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
`ifdef SYS_DECODER_BERR_EN
          else if (miss) begin
            cpu_berr_n <= 1'b0;
            state      <= ST_BERR;
          end
`endif
          else if (need_ready) begin
            state <= ST_READY;
          end else begin
            cpu_dtack_n <= 1'b0;
            state       <= ST_ACK;
          end
        end

        ST_READY: begin
`ifdef SYS_DECODER_BERR_EN
          tmo_cnt <= tmo_next;
`endif
          if (cpu_as_n) begin
            cs    <= '0;
            state <= ST_IDLE;
          end
`ifdef SYS_DECODER_BERR_EN
          else if (tmo_hit) begin
            cs         <= '0;
            cpu_berr_n <= 1'b0;
            state      <= ST_BERR;
          end
`endif
          else if (ext_ready) begin
            cpu_dtack_n <= 1'b0;
            state       <= ST_ACK;
          end else begin
            state <= ST_READY;
          end
        end

        ST_ACK: begin
          if (cpu_as_n) begin
            cs          <= '0;
            cpu_dtack_n <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            state <= ST_ACK;
          end
        end

        ST_BERR: begin
          if (cpu_as_n) begin
            cs    <= '0;
`ifdef SYS_DECODER_BERR_EN
            cpu_berr_n <= 1'b1;
`endif
            state <= ST_IDLE;
          end else begin
            state <= ST_BERR;
          end
        end

        default: begin
          cs          <= '0;
          cpu_dtack_n <= 1'b1;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sys_decoder.sv
// tb_sys_decoder -- directed, table-driven bench for sys_decoder using the
// demo PCB region table from sys_decoder_pkg.
module tb_sys_decoder;
  import sys_decoder_pkg::*;

  localparam int NR = PCB_DEMO_REGIONS;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic [23:0]   cpu_a;
  logic          cpu_as_n;
  logic          ext_ready;
  logic [NR-1:0] cs;
  logic          cpu_dtack_n;
  logic          cpu_berr_n;
  logic [4:0]    hit_idx;

  int checks   = 0;
  int failures = 0;

  sys_decoder #(
    .NUM_REGIONS  (NR),
    .ADDR_W       (PCB_DEMO_ADDR_W),
    .WAIT_W       (PCB_DEMO_WAIT_W),
    .TIMEOUT      (255),
    .REGION_BASE  (PCB_DEMO_BASE),
    .REGION_SHIFT (PCB_DEMO_SHIFT),
    .REGION_WAIT  (PCB_DEMO_WAIT),
    .REGION_READY (PCB_DEMO_READY)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .cpu_a       (cpu_a),
    .cpu_as_n    (cpu_as_n),
    .ext_ready   (ext_ready),
    .cs          (cs),
    .cpu_dtack_n (cpu_dtack_n),
    .cpu_berr_n  (cpu_berr_n),
    .hit_idx     (hit_idx)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    string       name;
    logic [23:0] addr;
    int          rdy_at;     // ext_ready high from edge k+rdy_at+1 on
    logic [7:0]  exp_cs;
    logic [4:0]  exp_idx;
    int          exp_lat;    // edges after k until dtack or berr
    logic        exp_dtack;  // dtack_n at end of cycle
    logic        exp_berr;   // berr_n at end of cycle
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    logic stable;
    tick();
    cpu_a     = v.addr;
    cpu_as_n  = 1'b0;
    ext_ready = 1'b0;
    tick();  // edge k
    check({v.name, ".cs"}, 32'(cs), 32'(v.exp_cs));
    if (v.exp_cs != 8'h00) check({v.name, ".idx"}, 32'(hit_idx), 32'(v.exp_idx));
    check({v.name, ".dtack_k"}, 32'(cpu_dtack_n), 32'd1);
    cpu_a  = ~v.addr;  // address may wander during the cycle
    n      = 0;
    stable = 1'b1;
    while (cpu_dtack_n && cpu_berr_n && n < 64) begin
      ext_ready = ((n + 1) > v.rdy_at);
      tick();
      n++;
      if (cs !== v.exp_cs) stable = 1'b0;
    end
    check({v.name, ".latency"}, 32'(n), 32'(v.exp_lat));
    check({v.name, ".cs_stable"}, 32'(stable), 32'd1);
    check({v.name, ".dtack_end"}, 32'(cpu_dtack_n), 32'(v.exp_dtack));
    check({v.name, ".berr_end"}, 32'(cpu_berr_n), 32'(v.exp_berr));
    cpu_as_n  = 1'b1;
    ext_ready = 1'b0;
    tick();
    check({v.name, ".cs_rel"}, 32'(cs), 32'd0);
    check({v.name, ".dtack_rel"}, 32'(cpu_dtack_n), 32'd1);
    check({v.name, ".berr_rel"}, 32'(cpu_berr_n), 32'd1);
  endtask

  initial begin
    logic held;
    vecs[0] = '{"r0_base0",   24'h01FFFE,  0, 8'h01, 5'd0,  1, 1'b0, 1'b1};
    vecs[1] = '{"r1_wait3",   24'h483000,  0, 8'h02, 5'd1,  4, 1'b0, 1'b1};
    vecs[2] = '{"overlap",    24'h404010,  0, 8'h04, 5'd2,  1, 1'b0, 1'b1};
    vecs[3] = '{"r3_ready",   24'h84ABCD, 11, 8'h08, 5'd3, 12, 1'b0, 1'b1};
    vecs[4] = '{"r4_wait2",   24'hC01234,  0, 8'h10, 5'd4,  3, 1'b0, 1'b1};
    vecs[5] = '{"r5_wait1",   24'h40F000,  0, 8'h20, 5'd5,  2, 1'b0, 1'b1};
    vecs[6] = '{"r6_rdy_early", 24'h2ABCDE, 0, 8'h40, 5'd6, 3, 1'b0, 1'b1};
    vecs[7] = '{"r7_wait15",  24'hE12345,  0, 8'h80, 5'd7, 16, 1'b0, 1'b1};
`ifdef SYS_DECODER_BERR_EN
    vecs[8] = '{"unmatched",  24'hF00000,  0, 8'h00, 5'd0,  1, 1'b1, 1'b0};
`else
    vecs[8] = '{"unmatched",  24'hF00000,  0, 8'h00, 5'd0,  1, 1'b0, 1'b1};
`endif

    // reset state, with the strobe low to show reset dominates
    reset_n   = 1'b0;
    cpu_a     = 24'h01FFFE;
    cpu_as_n  = 1'b0;
    ext_ready = 1'b0;
    repeat (3) tick();
    check("reset.cs", 32'(cs), 32'd0);
    check("reset.idx", 32'(hit_idx), 32'd0);
    check("reset.dtack", 32'(cpu_dtack_n), 32'd1);
    check("reset.berr", 32'(cpu_berr_n), 32'd1);
    cpu_as_n = 1'b1;
    reset_n  = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // ACK holds while AS stays low; then a back-to-back cycle after one IDLE edge
    cpu_a = 24'h01FFFE;
    cpu_as_n = 1'b0;
    tick();  // k
    tick();  // k+1
    check("hold.dtack_k1", 32'(cpu_dtack_n), 32'd0);
    repeat (3) tick();
    check("hold.dtack", 32'(cpu_dtack_n), 32'd0);
    check("hold.cs", 32'(cs), 32'h01);
    cpu_as_n = 1'b1;
    tick();  // back in IDLE
    check("b2b.cs_rel", 32'(cs), 32'd0);
    check("b2b.dtack_rel", 32'(cpu_dtack_n), 32'd1);
    cpu_a = 24'h483000;
    cpu_as_n = 1'b0;
    tick();
    check("b2b.cs", 32'(cs), 32'h02);
    check("b2b.idx", 32'(hit_idx), 32'd1);
    repeat (3) tick();
    check("b2b.dtack_k3", 32'(cpu_dtack_n), 32'd1);
    tick();
    check("b2b.dtack_k4", 32'(cpu_dtack_n), 32'd0);
    cpu_as_n = 1'b1;
    tick();
    check("b2b.dtack_rel2", 32'(cpu_dtack_n), 32'd1);

    // aborted cycle in WAIT: no dtack ever
    cpu_a = 24'h483000;
    cpu_as_n = 1'b0;
    tick();  // k
    check("abort.cs_k", 32'(cs), 32'h02);
    cpu_as_n = 1'b1;
    tick();
    check("abort.cs", 32'(cs), 32'd0);
    held = 1'b1;
    repeat (6) begin
      tick();
      if (cpu_dtack_n !== 1'b1) held = 1'b0;
    end
    check("abort.no_dtack", 32'(held), 32'd1);

    // reset in WAIT with counter 2, strobe kept low across release
    cpu_a = 24'hC01234;
    cpu_as_n = 1'b0;
    tick();  // k: counter loaded with 2
    check("rstmid.cs_k", 32'(cs), 32'h10);
    reset_n = 1'b0;
    tick();
    check("rstmid.cs", 32'(cs), 32'd0);
    check("rstmid.idx", 32'(hit_idx), 32'd0);
    check("rstmid.dtack", 32'(cpu_dtack_n), 32'd1);
    check("rstmid.berr", 32'(cpu_berr_n), 32'd1);
    reset_n = 1'b1;
    tick();  // new cycle accepted here
    check("rstmid.restart_cs", 32'(cs), 32'h10);
    check("rstmid.restart_idx", 32'(hit_idx), 32'd4);
    tick();
    tick();
    check("rstmid.dtack_k2", 32'(cpu_dtack_n), 32'd1);
    tick();
    check("rstmid.dtack_k3", 32'(cpu_dtack_n), 32'd0);
    cpu_as_n = 1'b1;
    tick();
    check("rstmid.cs_rel", 32'(cs), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
